// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path.
//   - state_e     : 4-bit FSM state encoding (also exported on the debug port)
//   - OP_*        : major opcode values (IR[6:0]) recognised by the controller
//   - SRCA_*/SRCB_*/ALUOP_* : datapath mux and ALU-class encodings
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear
//   en    : count this cycle
//   count : current count, wraps modulo 2^CNT_W
module instret_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = en ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencing controller.
// Steps each instruction through FETCH/DECODE/execute/memory/writeback and
// drives the shared datapath controls from the current state.
//   clk, reset      : clock and asynchronous active-high reset
//   Opcode          : IR[6:0], read in DECODE and MEM_ADDR only
//   zero            : ALU zero flag, used in BRANCH
//   mem_ready       : memory access completes this cycle
//   PCWrite..ALUOp  : datapath control outputs
//   illegal         : pulse in DECODE on an unrecognised opcode
//   instret         : retired-instruction count
//   state           : current state (debug)
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCSource,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  state_e state_q;
  state_e state_d;
  logic   retire;
  logic   mem_rdy;

  // Without the handshake every memory access is assumed single-cycle.
  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // Next state; retire marks the edge that leaves a terminal state.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_NOP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (Opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: if (mem_rdy) state_d = S_MEM_WB;
      S_MEM_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WRITE: begin
        if (mem_rdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R: state_d = S_ALU_WB;
      S_EXEC_I: state_d = S_ALU_WB;
      S_ALU_WB, S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Output decode: Moore on state, except the fetch-accept and branch-taken
  // PC/IR enables, which follow mem_ready and zero within the cycle.
  always_comb begin
    PCWrite  = 1'b0;
    PCSource = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_RS2;
    ALUOp    = ALUOP_ADD;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
      end
      S_DECODE: begin
        // Branch target (OldPC + imm) lands in ALUOut ahead of BRANCH.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (Opcode)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_NOP: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR, S_EXEC_I: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALU_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = SRCA_RS1;
        ALUOp    = ALUOP_SUB;
        PCSource = 1'b1;
        PCWrite  = zero;
      end
      default: ;
    endcase
  end

  instret_counter #(.CNT_W(CNT_W)) u_instret (
    .clk   (clk),
    .reset (reset),
    .en    (retire),
    .count (instret)
  );

  assign state = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Sequencing controller for the multicycle RV32I datapath. It replaces per-instruction combinational decode with a state machine that runs each instruction through fetch, decode, execute, memory and writeback over several clock cycles. It drives the shared ALU, memory port, PC and register-file enables from the instruction-register opcode. It stalls on a memory-ready handshake and counts retired instructions.

## Interface
- `MEM_HANDSHAKE`, default 1: when 1, memory states wait for `mem_ready`; when 0, `mem_ready` is ignored and treated as 1.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `Opcode` in 7: IR[6:0]. Stable from DECODE until the return to FETCH.
- `zero` in 1: ALU zero flag, sampled in BRANCH.
- `mem_ready` in 1: memory completed the current read/write this cycle.
- `PCWrite` out 1: PC load enable.
- `PCSource` out 1: PC input select. 0 = ALU result, 1 = ALUOut register.
- `IRWrite` out 1: instruction register load enable.
- `IorD` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `MemtoReg` out 1: write-back data select. 1 = MDR, 0 = ALUOut.
- `RegWrite` out 1: register-file write enable.
- `ALUSrcA` out 2: ALU A select. 00 = PC, 01 = rs1, 10 = OldPC.
- `ALUSrcB` out 2: ALU B select. 00 = rs2, 01 = constant 4, 10 = immediate.
- `ALUOp` out 2: ALU control class. 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- `illegal` out 1: one-cycle pulse on an unrecognised opcode.
- `instret` out CNT_W: retired-instruction count.
- `state` out 4: current state encoding, for debug only.

## Operation
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH.
- Any output not listed for a state is 0.
- RESET: all outputs 0. Next state is unconditionally FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00.
  - When `mem_ready`: IRWrite=1, PCWrite=1, PCSource=0, go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00. This precomputes the branch target into ALUOut. Dispatch on `Opcode`:
  - 0000011 (load) or 0100011 (store) → MEM_ADDR.
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 1100011 → BRANCH.
  - 0000000 (NOP) → FETCH; counts as retired.
  - Any other opcode → FETCH with `illegal`=1 for that cycle; not counted.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Go to MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: MemRead=1, IorD=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1. Go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until `mem_ready`, then go to FETCH.
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Go to ALU_WB.
- EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Go to ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0. Go to FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=`zero`. Go to FETCH.
- `instret` increments by 1 in the cycle the FSM leaves a terminal state for FETCH:
  - Terminal states are MEM_WB, MEM_WRITE (when `mem_ready`), ALU_WB, BRANCH, and DECODE on a NOP.
  - The counter wraps modulo 2^CNT_W.

## Timing
- Outputs are Moore decodes of `state`. The exceptions are IRWrite/PCWrite in FETCH (qualified by `mem_ready`) and PCWrite in BRANCH (qualified by `zero`), which are Mealy.
- Reset values: `state`=RESET, `instret`=0, `illegal`=0, all control outputs 0.
- Reset is asynchronous: asserting `reset` in any state, including mid-wait in MEM_READ/MEM_WRITE, forces RESET immediately. The aborted instruction is not counted.
- Cycles per instruction with zero-wait memory: load 5, store 4, R-type 4, I-type 4, branch 3, NOP 2, illegal 2.
- Each cycle that `mem_ready` is low in FETCH, MEM_READ or MEM_WRITE adds one cycle. During a wait, all outputs stay constant.
- `Opcode` is sampled only in DECODE and MEM_ADDR. Changes in other states have no effect.
- With `MEM_HANDSHAKE`=0, every memory state lasts exactly one cycle.

## Structure
- Shared package `rv_ctrl_pkg` holds:
  - The state enum (4-bit).
  - Opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_NOP.
  - ALUSrcA/ALUSrcB/ALUOp encodings.
- The single-cycle control decoder's opcode constants move into this package.
- One sub-module, `instret_counter`: CNT_W wide, with enable and asynchronous reset.
- The next-state logic and the output decode live in the top module.

## Test plan
- Reset then `mem_ready`=1, `Opcode`=0110011 → states RESET, FETCH, DECODE, EXEC_R, ALU_WB, FETCH. RegWrite=1 only in ALU_WB. `instret`=1.
- Load with `mem_ready` low for 3 cycles in MEM_READ → 8 cycles total. MemRead and IorD held at 1 throughout the wait. MEM_WB has MemtoReg=1 and RegWrite=1.
- Branch with `zero`=1, then a branch with `zero`=0 → PCWrite=1 and PCSource=1 in the first BRANCH state; PCWrite=0 in the second. Each branch is 3 cycles.
- `Opcode`=1111111 → `illegal` pulses for exactly 1 cycle in DECODE, the FSM returns to FETCH, and `instret` is unchanged.
- Assert `reset` mid-MEM_WRITE while `mem_ready`=0 → immediate RESET. All outputs 0 and `instret` cleared. Resumes FETCH after release.
- CNT_W=4, run 17 NOPs → `instret`=1 after wrap; each NOP takes 2 cycles.
